// File: rtl/lsu_pkg.sv
// Shared types and mask helpers for the data-memory load/store master.
package lsu_pkg;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned NBYTES = 8;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } lsu_size_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } lsu_state_t;

    // Byte-lane enables for an access of the given size at byte offset off.
    function automatic logic [NBYTES-1:0] byte_mask(input lsu_size_t size, input logic [2:0] off);
        logic [NBYTES-1:0] base;
        case (size)
            SZ_B:    base = 8'h01;
            SZ_H:    base = 8'h03;
            SZ_W:    base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return NBYTES'(base << off);
    endfunction

    // Widen each byte enable to eight bit enables.
    function automatic logic [XLEN-1:0] expand_mask(input logic [NBYTES-1:0] bm);
        logic [XLEN-1:0] m;
        m = '0;
        for (int i = 0; i < int'(NBYTES); i++) begin
            m[i*8 +: 8] = {8{bm[i]}};
        end
        return m;
    endfunction

    // Natural alignment check; bytes can never be misaligned.
    function automatic logic misaligned(input lsu_size_t size, input logic [2:0] off);
        logic bad;
        case (size)
            SZ_H:    bad = off[0];
            SZ_W:    bad = |off[1:0];
            SZ_D:    bad = |off;
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_lsu_master_load_align.sv
// Right-aligns the addressed lanes of a read beat and sign/zero extends them.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [XLEN-1:0] rdata_i,
    input  logic [2:0]      off_i,
    input  lsu_size_t       size_i,
    input  logic            unsigned_i,
    output logic [XLEN-1:0] ext_data_c
);

    logic [XLEN-1:0] shifted;

    // Shift the selected lanes down to bit 0, then truncate and extend.
    always_comb begin
        shifted    = rdata_i >> {off_i, 3'b000};
        ext_data_c = shifted;
        case (size_i)
            SZ_B:    ext_data_c = unsigned_i ? {56'h0, shifted[7:0]}
                                             : {{56{shifted[7]}}, shifted[7:0]};
            SZ_H:    ext_data_c = unsigned_i ? {48'h0, shifted[15:0]}
                                             : {{48{shifted[15]}}, shifted[15:0]};
            SZ_W:    ext_data_c = unsigned_i ? {32'h0, shifted[31:0]}
                                             : {{32{shifted[31]}}, shifted[31:0]};
            default: ext_data_c = shifted;
        endcase
    end

endmodule

// File: rtl/dmem_lsu_master.sv
// Single-outstanding load/store initiator for the single-cycle data-memory port.
module dmem_lsu_master
    import lsu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] req_addr,
    input  logic            req_wen,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic            dmem_en,
    output logic [XLEN-1:0] dmem_addr,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [XLEN-1:0] dmem_wmask,
    output logic            dmem_wen
);

    lsu_state_t      state_q;
    logic [2:0]      off_q;
    lsu_size_t       size_q;
    logic            uns_q;
    logic            wen_q;
    logic            req_ready_q;
    logic            resp_valid_q;
    logic            resp_err_q;
    logic [XLEN-1:0] resp_rdata_q;
    logic            dmem_en_q;
    logic            dmem_wen_q;
    logic [XLEN-1:0] dmem_addr_q;
    logic [XLEN-1:0] dmem_wdata_q;
    logic [XLEN-1:0] dmem_wmask_q;

    lsu_size_t       req_size_c;
    logic [XLEN-1:0] load_data_c;

    assign req_size_c = lsu_size_t'(req_size);

    lsu_load_align u_load_align (
        .rdata_i    (dmem_rdata),
        .off_i      (off_q),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .ext_data_c (load_data_c)
    );

    // FSM with request latches; every output is registered for the state it enters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            off_q        <= 3'd0;
            size_q       <= SZ_B;
            uns_q        <= 1'b0;
            wen_q        <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            dmem_en_q    <= 1'b0;
            dmem_wen_q   <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            dmem_wmask_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid && req_ready_q) begin
                        off_q       <= req_addr[2:0];
                        size_q      <= req_size_c;
                        uns_q       <= req_unsigned;
                        wen_q       <= req_wen;
                        req_ready_q <= 1'b0;
                        if (misaligned(req_size_c, req_addr[2:0])) begin
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                            state_q      <= ST_RESP;
                        end else begin
                            dmem_en_q    <= 1'b1;
                            dmem_wen_q   <= req_wen;
                            dmem_addr_q  <= {req_addr[XLEN-1:3], 3'b000};
                            dmem_wdata_q <= req_wen ? XLEN'(req_wdata << {req_addr[2:0], 3'b000}) : '0;
                            dmem_wmask_q <= req_wen ? expand_mask(byte_mask(req_size_c, req_addr[2:0])) : '0;
                            state_q      <= ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: begin
                    dmem_en_q    <= 1'b0;
                    dmem_wen_q   <= 1'b0;
                    dmem_addr_q  <= '0;
                    dmem_wdata_q <= '0;
                    dmem_wmask_q <= '0;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= wen_q ? '0 : load_data_c;
                    state_q      <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= '0;
                        req_ready_q  <= 1'b1;
                        state_q      <= ST_IDLE;
                    end
                end
                default: begin
                    req_ready_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign dmem_en    = dmem_en_q;
    assign dmem_wen   = dmem_wen_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wdata = dmem_wdata_q;
    assign dmem_wmask = dmem_wmask_q;

endmodule

// File: tb/tb_dmem_lsu_master.sv
// Scoreboard bench for dmem_lsu_master with a small byte-masked RAM responder.
module tb_dmem_lsu_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic        req_wen;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic        dmem_en;
    logic [63:0] dmem_addr;
    logic [63:0] dmem_rdata;
    logic [63:0] dmem_wdata;
    logic [63:0] dmem_wmask;
    logic        dmem_wen;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
    } resp_t;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] wmask;
        logic        wen;
    } beat_t;

    resp_t       resp_q[$];
    beat_t       beat_q[$];
    logic [63:0] mem [16];
    int          n_cmp = 0;
    int          n_bad = 0;

    dmem_lsu_master dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_wen      (req_wen),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .dmem_en      (dmem_en),
        .dmem_addr    (dmem_addr),
        .dmem_rdata   (dmem_rdata),
        .dmem_wdata   (dmem_wdata),
        .dmem_wmask   (dmem_wmask),
        .dmem_wen     (dmem_wen)
    );

    always #5 clk = ~clk;

    // RAM responder: combinational read, byte-masked commit on the clock edge.
    assign dmem_rdata = dmem_en ? mem[dmem_addr[6:3]] : 64'h0;

    always @(posedge clk) begin
        if (dmem_en && dmem_wen)
            mem[dmem_addr[6:3]] = (mem[dmem_addr[6:3]] & ~dmem_wmask) | (dmem_wdata & dmem_wmask);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Response monitor: pop and compare on every handshake.
    always @(negedge clk) begin
        if (rst_n && resp_valid && resp_ready) begin
            check("resp_expected", 64'(resp_q.size() > 0), 64'd1);
            if (resp_q.size() > 0) begin
                resp_t e;
                e = resp_q.pop_front();
                check("resp_rdata", resp_rdata, e.rdata);
                check("resp_err", 64'(resp_err), 64'(e.err));
            end
        end
    end

    // Memory-beat monitor: pop and compare on every enabled beat.
    always @(negedge clk) begin
        if (rst_n && dmem_en) begin
            check("beat_expected", 64'(beat_q.size() > 0), 64'd1);
            if (beat_q.size() > 0) begin
                beat_t b;
                b = beat_q.pop_front();
                check("beat_addr", dmem_addr, b.addr);
                check("beat_wdata", dmem_wdata, b.wdata);
                check("beat_wmask", dmem_wmask, b.wmask);
                check("beat_wen", 64'(dmem_wen), 64'(b.wen));
            end
        end
    end

    // Issue one request, queue its expectations, and measure cycles to resp_valid.
    task automatic do_req(input logic [63:0] a, input logic w, input logic [1:0] sz, input logic u,
                          input logic [63:0] wd, input logic [63:0] exp_rd, input logic exp_err,
                          input logic [63:0] exp_bwd, input logic [63:0] exp_bmask, input int exp_lat);
        resp_t r;
        beat_t b;
        int    n;
        int    lat;
        r.rdata = exp_rd;
        r.err   = exp_err;
        resp_q.push_back(r);
        if (!exp_err) begin
            b.addr  = {a[63:3], 3'b000};
            b.wdata = exp_bwd;
            b.wmask = exp_bmask;
            b.wen   = w;
            beat_q.push_back(b);
        end
        @(negedge clk);
        req_addr     = a;
        req_wen      = w;
        req_size     = sz;
        req_unsigned = u;
        req_wdata    = wd;
        req_valid    = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("req_accept_timeout", 64'(n < 50), 64'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (resp_valid) break;
        end
        check("resp_latency", 64'(lat), 64'(exp_lat));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 64'h0;
        resp_ready   = 1'b1;
        req_valid    = 1'b1;
        req_addr     = 64'h8000_0000;
        req_wen      = 1'b1;
        req_size     = 2'd3;
        req_unsigned = 1'b0;
        req_wdata    = 64'h1234_5678_9ABC_DEF0;
        rst_n        = 1'b0;

        // Reset held two cycles with a request pending
        repeat (2) @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_err", 64'(resp_err), 64'd0);
        check("rst_resp_rdata", resp_rdata, 64'h0);
        check("rst_dmem_en", 64'(dmem_en), 64'd0);
        check("rst_dmem_wen", 64'(dmem_wen), 64'd0);
        check("rst_dmem_addr", dmem_addr, 64'h0);
        check("rst_dmem_wdata", dmem_wdata, 64'h0);
        check("rst_dmem_wmask", dmem_wmask, 64'h0);
        check("rst_no_write", mem[0], 64'h0);
        req_valid = 1'b0;
        rst_n     = 1'b1;

        // Store word at offset 4
        do_req(64'h8000_0004, 1'b1, 2'd2, 1'b0, 64'h0000_0000_DEAD_BEEF, 64'h0, 1'b0,
               64'hDEAD_BEEF_0000_0000, 64'hFFFF_FFFF_0000_0000, 2);
        check("mem_store_word", mem[0], 64'hDEAD_BEEF_0000_0000);

        // Signed and unsigned byte loads at offset 3
        mem[0] = 64'h0000_0000_8000_0000;
        do_req(64'h8000_0003, 1'b0, 2'd0, 1'b0, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 64'h0, 64'h0, 2);
        do_req(64'h8000_0003, 1'b0, 2'd0, 1'b1, 64'h0, 64'h0000_0000_0000_0080, 1'b0, 64'h0, 64'h0, 2);

        // Misaligned half: error one cycle after accept, no beat
        do_req(64'h8000_0001, 1'b0, 2'd1, 1'b0, 64'h0, 64'h0, 1'b1, 64'h0, 64'h0, 1);
        check("misalign_err_now", 64'(resp_err), 64'd1);
        check("misalign_no_beat", 64'(dmem_en), 64'd0);

        // Double load under five cycles of backpressure
        mem[1] = 64'h1122_3344_5566_7788;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        do_req(64'h8000_0008, 1'b0, 2'd3, 1'b0, 64'h0, 64'h1122_3344_5566_7788, 1'b0, 64'h0, 64'h0, 2);
        req_addr     = 64'h8000_0009;
        req_wen      = 1'b1;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_wdata    = 64'h0000_0000_0000_00A5;
        req_valid    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_resp_valid", 64'(resp_valid), 64'd1);
            check("bp_resp_rdata", resp_rdata, 64'h1122_3344_5566_7788);
            check("bp_resp_err", 64'(resp_err), 64'd0);
            check("bp_req_ready", 64'(req_ready), 64'd0);
            check("bp_no_beat", 64'(dmem_en), 64'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 resp_ready = 1'b1;
        do_req(64'h8000_0009, 1'b1, 2'd0, 1'b0, 64'h0000_0000_0000_00A5, 64'h0, 1'b0,
               64'h0000_0000_0000_A500, 64'h0000_0000_0000_FF00, 2);
        check("mem_store_byte", mem[1], 64'h1122_3344_5566_A588);

        // Signed half with sign bit set, unsigned word from upper lanes
        do_req(64'h8000_0008, 1'b0, 2'd1, 1'b0, 64'h0, 64'hFFFF_FFFF_FFFF_A588, 1'b0, 64'h0, 64'h0, 2);
        do_req(64'h8000_000C, 1'b0, 2'd2, 1'b1, 64'h0, 64'h0000_0000_1122_3344, 1'b0, 64'h0, 64'h0, 2);

        // Misaligned word and double
        do_req(64'h8000_0002, 1'b0, 2'd2, 1'b0, 64'h0, 64'h0, 1'b1, 64'h0, 64'h0, 1);
        do_req(64'h8000_0014, 1'b1, 2'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 64'h0, 1);
        check("mem_no_misaligned_write", mem[2], 64'h0);

        // Reset asserted during a store's ACCESS cycle
        @(negedge clk);
        check("rst_acc_ready", 64'(req_ready), 64'd1);
        req_addr  = 64'h8000_0010;
        req_wen   = 1'b1;
        req_size  = 2'd3;
        req_wdata = 64'hCAFE_F00D_1234_5678;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        check("rst_acc_en_before", 64'(dmem_en), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_acc_en_drop", 64'(dmem_en), 64'd0);
        check("rst_acc_wen_drop", 64'(dmem_wen), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_acc_no_resp", 64'(resp_valid), 64'd0);
            check("rst_acc_idle", 64'(req_ready), 64'd1);
        end
        check("rst_acc_no_write", mem[2], 64'h0);

        repeat (3) @(negedge clk);
        check("resp_queue_drained", 64'(resp_q.size()), 64'd0);
        check("beat_queue_drained", 64'(beat_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_lsu_master.md
# dmem_lsu_master

Load/store initiator that drives the single-cycle data-memory port (`dmem_en/addr/wdata/wmask/wen`, `dmem_rdata`) from the CPU's memory stage.

- Accepts one load or store request at a time over a valid/ready handshake.
- Checks alignment, then issues exactly one 8-byte-aligned memory beat with byte-lane-shifted write data and mask.
- Captures and extends read data, and returns a response over a second valid/ready handshake.
- It is the requesting end of the data-memory port whose responder is the simulation RAM.

## Interface
Parameters: none (64-bit data path fixed).

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request.
- `req_addr` in 64: byte address.
- `req_wen` in 1: 1 = store, 0 = load.
- `req_size` in 2: 0 = byte, 1 = half, 2 = word, 3 = double.
- `req_unsigned` in 1: zero-extend the load result (ignored for stores and for size 3).
- `req_wdata` in 64: store data, right-justified.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: consumer takes the response.
- `resp_rdata` out 64: extended load data; 0 for stores and errors.
- `resp_err` out 1: misaligned access, no memory beat issued.
- `dmem_en` out 1: memory beat enable.
- `dmem_addr` out 64: `{req_addr[63:3], 3'b000}`.
- `dmem_rdata` in 64: combinational read data, valid in the same cycle as `dmem_en`.
- `dmem_wdata` out 64: store data shifted left by `addr[2:0]*8`.
- `dmem_wmask` out 64: bit mask, each selected byte = 8'hFF.
- `dmem_wen` out 1: write enable. Memory commits on the `posedge clk` that ends a cycle with `dmem_en & dmem_wen`.

## Operation
- **States:**
  - IDLE: `req_ready = 1`.
  - ACCESS: one cycle; `dmem_en = 1`.
  - RESP: `resp_valid = 1`.
- **IDLE:**
  - On `req_valid & req_ready`, latch addr/wen/size/unsigned/wdata.
  - If aligned, go to ACCESS.
  - If misaligned, set `err` and go directly to RESP.
  - Misaligned means `size` 1 with `addr[0] != 0`, `size` 2 with `addr[1:0] != 0`, or `size` 3 with `addr[2:0] != 0`.
- **ACCESS:** drive `dmem_en = 1`, `dmem_wen = latched wen`, and `dmem_addr`/`dmem_wdata`/`dmem_wmask` from latched fields.
  - Byte-mask base: 0x1, 0x3, 0xF, 0xFF for sizes 0..3, shifted left by `addr[2:0]`, then expanded to bits.
  - Loads: `dmem_wmask = 0` and `dmem_wdata = 0`.
  - At the end of the cycle, register the response data.
  - Loads: `dmem_rdata >> (addr[2:0]*8)`, truncated to size, then sign- or zero-extended to 64.
  - Stores: 0.
  - Go to RESP.
- **RESP:** hold `resp_valid`, `resp_rdata` and `resp_err` stable until `resp_ready`, then go to IDLE.
  - `resp_ready` may already be high on entry; RESP then lasts one cycle.
- Outside ACCESS, all `dmem_*` outputs are 0.
- Addresses pass through unmodified. Base-offset translation belongs to the memory.
- Only one outstanding request at a time; `req_ready` is 0 in ACCESS and RESP.

## Timing
- **Reset (async):**
  - state = IDLE, `req_ready = 1`.
  - `resp_valid`, `resp_err`, `resp_rdata` = 0.
  - All `dmem_*` outputs = 0.
- **Reset mid-ACCESS:** `dmem_en`/`dmem_wen` drop immediately. A store in flight does not commit unless the edge precedes reset assertion. No response is produced.
- **Load/store latency:**
  - Request accepted at edge N.
  - ACCESS occupies cycle N..N+1.
  - `resp_valid` rises after edge N+1.
  - Minimum 3 cycles per request.
- **Misaligned latency:** `resp_valid` rises after edge N; `dmem_en` never asserts.
- `dmem_*` outputs come from registered state and latched fields only; there is no combinational path from `req_*` to `dmem_*`.
- `resp_rdata` is registered and has no combinational path from `dmem_rdata` to `resp_*`.

## Structure
- Package `lsu_pkg`:
  - `lsu_size_t` (B/H/W/D).
  - `lsu_state_t` (IDLE/ACCESS/RESP).
  - Functions `byte_mask(size, off)` → 8 bits and `expand_mask(8b)` → 64 bits.
- Sub-module `lsu_load_align`: combinational shift/truncate/extend of `dmem_rdata` by offset, size and unsigned.
- Top block holds the FSM, request latches and response registers.

## Test plan
- **Reset:** hold `rst_n = 0` two cycles with `req_valid = 1` → `req_ready = 1`, all `dmem_*` = 0, `resp_valid = 0`, no beat.
- **Store word:** addr 0x8000_0004, data 0xDEADBEEF → in ACCESS:
  - `dmem_addr` 0x8000_0000.
  - `dmem_wmask` 0xFFFF_FFFF_0000_0000.
  - `dmem_wdata` 0xDEADBEEF_0000_0000.
  - `wen = 1`.
  - Then `resp_valid` with `rdata = 0`, `err = 0`.
- **Signed byte load:** addr 0x8000_0003, `dmem_rdata` 0x0000_0000_8000_0000 →
  - `resp_rdata` 0xFFFF_FFFF_FFFF_FF80.
  - With `req_unsigned = 1`: 0x80.
- **Misaligned half:** addr 0x8000_0001 → `resp_err = 1` one cycle after accept, `dmem_en` never high, `rdata = 0`.
- **Backpressure:** hold `resp_ready = 0` for 5 cycles after a double load of 0x1122_3344_5566_7788 → response stable all 5 cycles, `req_ready = 0`. Accept the next request only after the handshake.
- **Reset during ACCESS of a store:** memory model records no write, FSM returns to IDLE, no response.
